alu_issue_sequencer: RTL and testbench

- Sequences operations into the combinational 2-bit datapath (8-bit instruction, two 2-bit operands; returns out0/out1, ok, ovf, instr_out).
- Requesters push {instruction, data0, data1} into a small FIFO over a valid/ready handshake.
- The sequencer issues one entry per cycle to the datapath and registers the datapath response into a result slot with its own valid/ready handshake.
- Optionally halts on a datapath error (ok=0), and keeps saturating error and overflow counters for software.

---
 rtl/alu_issue_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//   Queues {instruction, data0, data1} requests in a small FIFO and issues
//   one entry per cycle to a combinational 2-bit ALU datapath. The datapath
//   response is captured into a single result slot with a valid/ready
//   handshake. An optional HALT state stops issue after an erroring op.
//   Saturating error and overflow counters are kept for software.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_instr/req_data0/req_data1 payload
//   dp_instruction/dp_data0/dp_data1   FIFO head to the datapath (0 when empty)
//   dp_out0/dp_out1/dp_instr_out/dp_ok/dp_ovf   datapath response
//   res_valid/res_ready    result slot handshake
//   res_out0/res_out1/res_instr/res_err/res_ovf   captured result
//   halted, clr_halt       HALT status and one-cycle release pulse
//   err_cnt, ovf_cnt       saturating event counters
module alu_issue_sequencer #(
  parameter int DEPTH       = 4,
  parameter bit HALT_ON_ERR = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_instr,
  input  logic [1:0]       req_data0,
  input  logic [1:0]       req_data1,
  output logic [7:0]       dp_instruction,
  output logic [1:0]       dp_data0,
  output logic [1:0]       dp_data1,
  input  logic [1:0]       dp_out0,
  input  logic [1:0]       dp_out1,
  input  logic [7:0]       dp_instr_out,
  input  logic             dp_ok,
  input  logic             dp_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_out0,
  output logic [1:0]       res_out1,
  output logic [7:0]       res_instr,
  output logic             res_err,
  output logic             res_ovf,
  output logic             halted,
  input  logic             clr_halt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  typedef logic [AW:0] ptr_t;

  state_t      state_q;
  ptr_t        wr_ptr_q, rd_ptr_q;
  ptr_t        wr_ptr_d, rd_ptr_d;
  logic [11:0] mem_q [DEPTH];
  logic [11:0] head;
  logic        empty, full, push, issue, slot_free;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign slot_free = ~res_valid | res_ready;
  assign issue     = (state_q == RUN) & ~empty & slot_free;
  assign wr_ptr_d  = push  ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
  assign rd_ptr_d  = issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

  // Head is forced to zero when empty so stale storage never reaches the datapath.
  assign head = empty ? 12'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign {dp_instruction, dp_data0, dp_data1} = head;

  // Storage is written only on an accepted push, so X payloads with
  // req_valid=0 never enter the FIFO.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= {req_instr, req_data0, req_data1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      halted    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      res_valid <= 1'b0;
      res_out0  <= '0;
      res_out1  <= '0;
      res_instr <= '0;
      res_err   <= 1'b0;
      res_ovf   <= 1'b0;
      err_cnt   <= '0;
      ovf_cnt   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;

      if (issue) begin
        res_valid <= 1'b1;
        res_out0  <= dp_out0;
        res_out1  <= dp_out1;
        res_instr <= dp_instr_out;
        res_err   <= ~dp_ok;
        res_ovf   <= dp_ovf;
        err_cnt   <= sat_inc(err_cnt, ~dp_ok);
        ovf_cnt   <= sat_inc(ovf_cnt, dp_ovf);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      case (state_q)
        RUN: begin
          // The erroring op's result is still captured above.
          if (issue && !dp_ok && HALT_ON_ERR) begin
            state_q <= HALT;
            halted  <= 1'b1;
          end
        end
        HALT: begin
          if (clr_halt) begin
            state_q <= RUN;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_instr = 8'h00;
  logic [1:0] req_data0 = 2'd0;
  logic [1:0] req_data1 = 2'd0;
  logic       res_ready = 1'b0;
  logic       clr_halt = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance A: HALT_ON_ERR=1
  logic       a_req_ready, a_res_valid, a_res_err, a_res_ovf, a_halted, a_dp_ok, a_dp_ovf;
  logic [7:0] a_dp_instruction, a_dp_instr_out, a_res_instr;
  logic [1:0] a_dp_data0, a_dp_data1, a_dp_out0, a_dp_out1, a_res_out0, a_res_out1;
  logic [7:0] a_err_cnt, a_ovf_cnt;

  // Instance B: HALT_ON_ERR=0
  logic       b_req_ready, b_res_valid, b_res_err, b_res_ovf, b_halted, b_dp_ok, b_dp_ovf;
  logic [7:0] b_dp_instruction, b_dp_instr_out, b_res_instr;
  logic [1:0] b_dp_data0, b_dp_data1, b_dp_out0, b_dp_out1, b_res_out0, b_res_out1;
  logic [7:0] b_err_cnt, b_ovf_cnt;

  // Datapath stubs
  assign a_dp_out0      = 2'(a_dp_data0 + a_dp_data1);
  assign a_dp_out1      = a_dp_data0 ^ a_dp_data1;
  assign a_dp_ovf       = ({1'b0, a_dp_data0} + {1'b0, a_dp_data1}) > 3'd3;
  assign a_dp_ok        = (a_dp_instruction != 8'hF0);
  assign a_dp_instr_out = a_dp_instruction;
  assign b_dp_out0      = 2'(b_dp_data0 + b_dp_data1);
  assign b_dp_out1      = b_dp_data0 ^ b_dp_data1;
  assign b_dp_ovf       = ({1'b0, b_dp_data0} + {1'b0, b_dp_data1}) > 3'd3;
  assign b_dp_ok        = (b_dp_instruction != 8'hF0);
  assign b_dp_instr_out = b_dp_instruction;

  alu_issue_sequencer #(.DEPTH(4), .HALT_ON_ERR(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_instr(req_instr), .req_data0(req_data0), .req_data1(req_data1),
    .dp_instruction(a_dp_instruction), .dp_data0(a_dp_data0), .dp_data1(a_dp_data1),
    .dp_out0(a_dp_out0), .dp_out1(a_dp_out1), .dp_instr_out(a_dp_instr_out),
    .dp_ok(a_dp_ok), .dp_ovf(a_dp_ovf), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_out0(a_res_out0), .res_out1(a_res_out1), .res_instr(a_res_instr),
    .res_err(a_res_err), .res_ovf(a_res_ovf), .halted(a_halted), .clr_halt(clr_halt),
    .err_cnt(a_err_cnt), .ovf_cnt(a_ovf_cnt)
  );

  alu_issue_sequencer #(.DEPTH(4), .HALT_ON_ERR(1'b0), .CNT_W(8)) dut_nh (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_instr(req_instr), .req_data0(req_data0), .req_data1(req_data1),
    .dp_instruction(b_dp_instruction), .dp_data0(b_dp_data0), .dp_data1(b_dp_data1),
    .dp_out0(b_dp_out0), .dp_out1(b_dp_out1), .dp_instr_out(b_dp_instr_out),
    .dp_ok(b_dp_ok), .dp_ovf(b_dp_ovf), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_out0(b_res_out0), .res_out1(b_res_out1), .res_instr(b_res_instr),
    .res_err(b_res_err), .res_ovf(b_res_ovf), .halted(b_halted), .clr_halt(clr_halt),
    .err_cnt(b_err_cnt), .ovf_cnt(b_ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; clr_halt = 1'b0; res_ready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic push_op(input logic [7:0] ins, input logic [1:0] d0, input logic [1:0] d1);
    req_valid = 1'b1; req_instr = ins; req_data0 = d0; req_data1 = d1;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total_cnt++;
    if ({a_res_valid, a_req_ready, a_halted} !== 3'b010)
      $display("FAIL reset_ctrl got valid/ready/halted=%b%b%b exp 010", a_res_valid, a_req_ready, a_halted);
    else pass_cnt++;
    total_cnt++;
    if ({a_res_out0, a_res_out1, a_res_instr, a_res_err, a_res_ovf} !== 14'd0)
      $display("FAIL reset_res got %h exp 0", {a_res_out0, a_res_out1, a_res_instr, a_res_err, a_res_ovf});
    else pass_cnt++;
    total_cnt++;
    if ({a_err_cnt, a_ovf_cnt} !== 16'd0)
      $display("FAIL reset_cnt got err=%0d ovf=%0d exp 0 0", a_err_cnt, a_ovf_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({a_dp_instruction, a_dp_data0, a_dp_data1} !== 12'd0)
      $display("FAIL reset_dp_empty got %h exp 0", {a_dp_instruction, a_dp_data0, a_dp_data1});
    else pass_cnt++;
  endtask

  task automatic test_single_op;
    do_reset;
    res_ready = 1'b1;
    push_op(8'h02, 2'd1, 2'd1);
    total_cnt++;
    if ({a_dp_instruction, a_dp_data0, a_dp_data1} !== {8'h02, 2'd1, 2'd1})
      $display("FAIL single_dp got %h exp %h", {a_dp_instruction, a_dp_data0, a_dp_data1}, {8'h02, 2'd1, 2'd1});
    else pass_cnt++;
    total_cnt++;
    if (a_res_valid !== 1'b0)
      $display("FAIL single_early_valid got %b exp 0", a_res_valid);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({a_res_valid, a_res_out0, a_res_ovf, a_res_err, a_res_instr} !== {1'b1, 2'd2, 1'b0, 1'b0, 8'h02})
      $display("FAIL single_result got v=%b o0=%0d ovf=%b err=%b ins=%h exp v=1 o0=2 ovf=0 err=0 ins=02",
               a_res_valid, a_res_out0, a_res_ovf, a_res_err, a_res_instr);
    else pass_cnt++;
    total_cnt++;
    if (a_dp_instruction !== 8'h00)
      $display("FAIL single_dp_after_pop got %h exp 00", a_dp_instruction);
    else pass_cnt++;
  endtask

  task automatic test_stream;
    int e, ea, eb;
    logic [5:0] exp_v;
    do_reset;
    res_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      req_valid = (c < 16);
      req_instr = 8'h00;
      req_data0 = 2'(c >> 2);
      req_data1 = 2'(c);
      tick;
      if (c >= 1 && c <= 16) begin
        e = c - 1; ea = e >> 2; eb = e & 3;
        exp_v = {1'b1, 2'(ea + eb), 2'(ea ^ eb), ((ea + eb) > 3)};
        total_cnt++;
        if ({a_res_valid, a_res_out0, a_res_out1, a_res_ovf} !== exp_v)
          $display("FAIL stream_res%0d got %b exp %b", e, {a_res_valid, a_res_out0, a_res_out1, a_res_ovf}, exp_v);
        else pass_cnt++;
      end else if (c == 17) begin
        total_cnt++;
        if (a_res_valid !== 1'b0)
          $display("FAIL stream_drained got %b exp 0", a_res_valid);
        else pass_cnt++;
      end
    end
    req_valid = 1'b0;
    total_cnt++;
    if ({a_ovf_cnt, a_err_cnt} !== {8'd6, 8'd0})
      $display("FAIL stream_cnt got ovf=%0d err=%0d exp 6 0", a_ovf_cnt, a_err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    do_reset;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (a_req_ready !== 1'b1)
        $display("FAIL bp_ready_before_push%0d got %b exp 1", i, a_req_ready);
      else pass_cnt++;
      push_op(8'(8'h10 + i), 2'(i), 2'd1);
    end
    total_cnt++;
    if ({a_req_ready, a_res_valid, a_res_instr, a_dp_instruction} !== {1'b0, 1'b1, 8'h10, 8'h11})
      $display("FAIL bp_full got ready=%b v=%b ins=%h head=%h exp 0 1 10 11",
               a_req_ready, a_res_valid, a_res_instr, a_dp_instruction);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({a_req_ready, a_res_valid, a_res_instr} !== {1'b0, 1'b1, 8'h10})
      $display("FAIL bp_hold got ready=%b v=%b ins=%h exp 0 1 10", a_req_ready, a_res_valid, a_res_instr);
    else pass_cnt++;
    res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick;
      total_cnt++;
      if ({a_res_valid, a_res_instr, a_res_out0, a_req_ready} !== {1'b1, 8'(8'h10 + i), 2'(i + 1), 1'b1})
        $display("FAIL bp_drain%0d got v=%b ins=%h o0=%0d ready=%b exp 1 %h %0d 1",
                 i, a_res_valid, a_res_instr, a_res_out0, a_req_ready, 8'(8'h10 + i), 2'(i + 1));
      else pass_cnt++;
    end
    tick;
    total_cnt++;
    if (a_res_valid !== 1'b0)
      $display("FAIL bp_empty got %b exp 0", a_res_valid);
    else pass_cnt++;
  endtask

  task automatic test_halt;
    do_reset;
    res_ready = 1'b1;
    push_op(8'hF0, 2'd3, 2'd1);
    push_op(8'h02, 2'd1, 2'd1);
    total_cnt++;
    if ({a_res_valid, a_res_instr, a_res_err, a_res_ovf, a_halted, a_err_cnt} !== {1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 8'd1})
      $display("FAIL halt_enter got v=%b ins=%h err=%b ovf=%b halted=%b errcnt=%0d exp 1 F0 1 1 1 1",
               a_res_valid, a_res_instr, a_res_err, a_res_ovf, a_halted, a_err_cnt);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({a_res_valid, a_halted, a_dp_instruction, a_dp_data0, a_dp_data1} !== {1'b0, 1'b1, 8'h02, 2'd1, 2'd1})
      $display("FAIL halt_stall got v=%b halted=%b head=%h d0=%0d d1=%0d exp 0 1 02 1 1",
               a_res_valid, a_halted, a_dp_instruction, a_dp_data0, a_dp_data1);
    else pass_cnt++;
    clr_halt = 1'b1;
    tick;
    clr_halt = 1'b0;
    total_cnt++;
    if ({a_halted, a_res_valid} !== 2'b00)
      $display("FAIL halt_clear got halted=%b v=%b exp 0 0", a_halted, a_res_valid);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({a_res_valid, a_res_instr, a_res_out0, a_res_err, a_err_cnt, a_ovf_cnt} !== {1'b1, 8'h02, 2'd2, 1'b0, 8'd1, 8'd1})
      $display("FAIL halt_resume got v=%b ins=%h o0=%0d err=%b errcnt=%0d ovfcnt=%0d exp 1 02 2 0 1 1",
               a_res_valid, a_res_instr, a_res_out0, a_res_err, a_err_cnt, a_ovf_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_halt;
    do_reset;
    res_ready = 1'b1;
    push_op(8'hF0, 2'd3, 2'd0);
    push_op(8'h02, 2'd2, 2'd1);
    total_cnt++;
    if ({b_res_valid, b_res_instr, b_res_err, b_res_ovf, b_halted} !== {1'b1, 8'hF0, 1'b1, 1'b0, 1'b0})
      $display("FAIL nohalt_first got v=%b ins=%h err=%b ovf=%b halted=%b exp 1 F0 1 0 0",
               b_res_valid, b_res_instr, b_res_err, b_res_ovf, b_halted);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({b_res_valid, b_res_instr, b_res_out0, b_res_err, b_halted, b_err_cnt} !== {1'b1, 8'h02, 2'd3, 1'b0, 1'b0, 8'd1})
      $display("FAIL nohalt_second got v=%b ins=%h o0=%0d err=%b halted=%b errcnt=%0d exp 1 02 3 0 0 1",
               b_res_valid, b_res_instr, b_res_out0, b_res_err, b_halted, b_err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    do_reset;
    res_ready = 1'b1;
    for (int c = 0; c < 260; c++) begin
      req_valid = 1'b1; req_instr = 8'h00; req_data0 = 2'd3; req_data1 = 2'd3;
      tick;
      if (c == 99) begin
        total_cnt++;
        if (a_ovf_cnt !== 8'd99)
          $display("FAIL sat_midcount got %0d exp 99", a_ovf_cnt);
        else pass_cnt++;
      end
    end
    req_valid = 1'b0;
    tick;
    tick;
    total_cnt++;
    if ({a_ovf_cnt, a_err_cnt} !== {8'hFF, 8'h00})
      $display("FAIL sat_final got ovf=%0d err=%0d exp 255 0", a_ovf_cnt, a_err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream;
    do_reset;
    res_ready = 1'b0;
    push_op(8'h21, 2'd3, 2'd3);
    push_op(8'h22, 2'd1, 2'd0);
    push_op(8'h23, 2'd2, 2'd0);
    push_op(8'h24, 2'd3, 2'd0);
    total_cnt++;
    if ({a_res_valid, a_ovf_cnt, a_dp_instruction} !== {1'b1, 8'd1, 8'h22})
      $display("FAIL midrst_pre got v=%b ovf=%0d head=%h exp 1 1 22", a_res_valid, a_ovf_cnt, a_dp_instruction);
    else pass_cnt++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total_cnt++;
    if ({a_res_valid, a_req_ready, a_halted, a_err_cnt, a_ovf_cnt, a_dp_instruction} !== {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'h00})
      $display("FAIL midrst_post got v=%b ready=%b halted=%b err=%0d ovf=%0d head=%h exp 0 1 0 0 0 00",
               a_res_valid, a_req_ready, a_halted, a_err_cnt, a_ovf_cnt, a_dp_instruction);
    else pass_cnt++;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total_cnt++;
      if (a_res_valid !== 1'b0)
        $display("FAIL midrst_stale%0d got v=%b ins=%h exp v=0", i, a_res_valid, a_res_instr);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_single_op;
    test_stream;
    test_backpressure;
    test_halt;
    test_no_halt;
    test_saturation;
    test_reset_midstream;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
